// File: rtl/fifo_pkg.sv
// Shared definitions for the conditional FIFO and its drain-side consumer.
package fifo_pkg;

  // Word width shared by the FIFO and every stage that reads from it.
  localparam int FIFO_DATA_WIDTH = 8;

  // Read-pacing states of the drain controller.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_SINGLE = 2'd2,
    S_GAP    = 2'd3
  } drain_state_t;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order holding buffer between the FIFO read port and the
// downstream valid/ready port. slot0 is always the head word.
module drain_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  do_pop;
  logic                  do_push;

  // An empty buffer cannot pop; a full one only accepts a push alongside a pop.
  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'd2) || do_pop);

  // Shift the second slot forward on pop and land new words behind the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (occ != 2'd0);
  assign head_data  = slot0;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drain controller: paces read strobes into the FIFO, captures the registered
// read data a cycle later into a 2-entry buffer, forwards it on valid/ready
// and counts forwarded words.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENB,
  input  logic                  fifoEmpty,
  input  logic                  fifoAlmostEmpty,
  input  logic                  fifoErrorEmpty,
  input  logic [DATA_WIDTH-1:0] fifoData,
  output logic                  fifoRead,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [CNT_WIDTH-1:0]  wordCount,
  output logic                  underrun
);

  drain_state_t          state;
  logic                  inflight;
  logic [1:0]            occ;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  pop;
  logic [2:0]            pending;
  logic                  state_permits;
  logic                  issue;

  // Pops are qualified by ENB so a frozen stage never drops the word it shows.
  assign pop = ENB && head_valid && outReady;

  // Words already held or in flight after this cycle's pop must leave a free slot.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // Only the burst and single-shot states may strobe the FIFO.
  always_comb begin
    state_permits = 1'b0;
    issue         = 1'b0;
    state_permits = (state == S_BURST) || (state == S_SINGLE);
    issue         = ENB && !fifoEmpty && (pending < 3'd2) && state_permits;
  end

  assign fifoRead = issue;

  // A read's data arrives next cycle, so the in-flight marker simply follows the strobe.
  always_ff @(posedge CLK) begin
    if (RST) inflight <= 1'b0;
    else     inflight <= issue;
  end

  // Read pacing: full rate when well stocked, one read per two cycles near empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else if (ENB) begin
      unique case (state)
        S_IDLE: begin
          if (!fifoEmpty) state <= fifoAlmostEmpty ? S_SINGLE : S_BURST;
        end
        S_BURST: begin
          if (fifoEmpty)            state <= S_IDLE;
          else if (fifoAlmostEmpty) state <= S_SINGLE;
        end
        S_SINGLE: begin
          if (fifoEmpty)  state <= S_IDLE;
          else if (issue) state <= S_GAP;
        end
        S_GAP: begin
          if (!fifoAlmostEmpty) state <= S_BURST;
          else if (!fifoEmpty)  state <= S_SINGLE;
          else                  state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Count accepted words and latch any empty-read error reported by the FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wordCount <= '0;
      underrun  <= 1'b0;
    end else if (ENB) begin
      if (pop)            wordCount <= wordCount + 1'b1;
      if (fifoErrorEmpty) underrun  <= 1'b1;
    end
  end

  // The in-flight word is captured even when ENB drops, so it is never lost.
  drain_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .rst       (RST),
    .push      (inflight),
    .push_data (fifoData),
    .pop       (pop),
    .occ       (occ),
    .head_valid(head_valid),
    .head_data (head_data)
  );

  assign outValid = head_valid;
  assign outData  = head_data;

endmodule
